muldiv_sequencer: RTL

- Multi-cycle controller and iterative datapath for unsigned multiply and divide on the 16-bit single-cycle core.
- The decoder raises an issue request. The block stalls the program counter for the duration of the operation, then presents one write-back beat to the register file.
- Shares the core's register address space and flag conventions.

---
 rtl/muldiv_pkg.sv | 11 +
 rtl/muldiv_step.sv | 26 ++
 rtl/muldiv_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and default widths for the multiply/divide sequencer.
package muldiv_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_D = 2;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic           op_i,
    input  logic [2*W-1:0] acc_i,
    input  logic [2*W-1:0] opa_i,
    input  logic [W-1:0]   opb_i,
    output logic [2*W-1:0] acc_o,
    output logic [2*W-1:0] opa_o,
    output logic [W-1:0]   opb_o
);
    logic [W:0] rem_sh;
    logic [W:0] diff;
    logic       ge;
    // Divide keeps the partial remainder in acc and shifts quotient bits into opa.
    assign rem_sh = {acc_i[W-1:0], opa_i[W-1]};
    assign diff   = rem_sh - {1'b0, opb_i};
    assign ge     = ~diff[W];
    assign acc_o  = (op_i == OP_DIV) ? {{W{1'b0}}, ge ? diff[W-1:0] : rem_sh[W-1:0]}
                                     : acc_i + (opb_i[0] ? opa_i : '0);
    assign opa_o  = (op_i == OP_DIV) ? {{W{1'b0}}, opa_i[W-2:0], ge} : opa_i << 1;
    assign opb_o  = (op_i == OP_DIV) ? opb_i : opb_i >> 1;
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: stalls the core while an iterative unsigned mul/div runs, then writes back once.
// Define MULDIV_EARLY_EXIT_EN to let multiply finish as soon as the multiplier is exhausted.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int L = DATA_W,
    parameter int A = ADDR_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         issue_valid_i,
    input  logic         issue_op_i,
    input  logic [L-1:0] operand_a_i,
    input  logic [L-1:0] operand_b_i,
    input  logic [A-1:0] issue_dest_i,
    output logic         stall_o,
    output logic         wb_valid_o,
    output logic [A-1:0] wb_addr_o,
    output logic [L-1:0] wb_data_o,
    output logic [2:0]   wb_flags_o
);
    localparam int CW = $clog2(L + 1);
`ifdef MULDIV_EARLY_EXIT_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*L-1:0] acc_q, acc_d, opa_q, opa_d, step_acc, step_opa;
    logic [L-1:0]   opb_q, opb_d, step_opb, res;
    logic           op_q, op_d;
    logic [A-1:0]   dest_q, dest_d, wb_addr_q, wb_addr_d;
    logic [L-1:0]   wb_data_q, wb_data_d;
    logic [2:0]     wb_flags_q, wb_flags_d, flags;
    logic           last, div0, mul0;

    muldiv_step #(.W(L)) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .opa_i (opa_q),
        .opb_i (opb_q),
        .acc_o (step_acc),
        .opa_o (step_opa),
        .opb_o (step_opb)
    );

    assign res  = (op_q == OP_MUL) ? step_acc[L-1:0] : step_opa[L-1:0];
    assign last = (cnt_q == CW'(1)) || (EARLY && op_q == OP_MUL && step_opb == '0);
    assign div0 = issue_op_i == OP_DIV && operand_b_i == '0;
    assign mul0 = EARLY && issue_op_i == OP_MUL && operand_b_i == '0;

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = res == '0;
        flags[FLAG_V] = (op_q == OP_MUL) && (|step_acc[2*L-1:L]);
    end

    // Stall is forced low during reset so the PC is never held by a stale state.
    assign stall_o    = rst_ni && ((state_q == IDLE && issue_valid_i) || state_q == BUSY);
    assign wb_valid_o = state_q == DONE;
    assign wb_addr_o  = wb_addr_q;
    assign wb_data_o  = wb_data_q;
    assign wb_flags_o = wb_flags_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        op_d       = op_q;
        dest_d     = dest_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_flags_d = wb_flags_q;
        case (state_q)
            IDLE: if (issue_valid_i) begin
                op_d    = issue_op_i;
                dest_d  = issue_dest_i;
                acc_d   = '0;
                cnt_d   = CW'(L);
                opa_d   = {{L{1'b0}}, operand_a_i};
                opb_d   = operand_b_i;
                state_d = BUSY;
                if (div0 || mul0) begin
                    state_d            = DONE;
                    wb_addr_d          = issue_dest_i;
                    wb_data_d          = div0 ? '1 : '0;
                    wb_flags_d         = '0;
                    wb_flags_d[FLAG_D] = div0;
                    wb_flags_d[FLAG_Z] = ~div0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                acc_d = step_acc;
                opa_d = step_opa;
                opb_d = step_opb;
                if (last) begin
                    state_d    = DONE;
                    wb_addr_d  = dest_q;
                    wb_data_d  = res;
                    wb_flags_d = flags;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= 1'b0;
            dest_q     <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_flags_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_flags_q <= wb_flags_d;
        end
    end
endmodule
